// File: rtl/parity_uart_rx.sv
// rtl/parity_uart_rx.sv - oversampling 8-bit UART receiver with parity and stop-bit checking
module parity_uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t          r_state;
  logic            r_rx_m;
  logic            r_rx_s;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_idx;
  logic [7:0]      r_shift;
  logic            r_par;
  logic [7:0]      r_data;
  logic            r_valid;
  logic            r_parity_err;
  logic            r_frame_err;
  logic            r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rx_m       <= 1'b1;
      r_rx_s       <= 1'b1;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_rx_m  <= rx;
      r_rx_s  <= r_rx_m;
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            r_cnt   <= '0;
            r_state <= S_START;
            r_busy  <= 1'b1;
          end
        end
        // Re-check the start bit at its midpoint so short glitches are rejected.
        S_START: begin
          if (r_cnt == CNT_HALF) begin
            r_cnt <= '0;
            if (!r_rx_s) begin
              r_idx   <= '0;
              r_state <= S_DATA;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt          <= '0;
            r_shift[r_idx] <= r_rx_s;
            r_idx          <= r_idx + 3'd1;
            if (r_idx == 3'd7) r_state <= S_PARITY;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_PARITY: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_par   <= r_rx_s;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        // Results register on the stop sample edge; IDLE is live while valid pulses.
        S_STOP: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt        <= '0;
            r_valid      <= 1'b1;
            r_data       <= r_shift;
            r_parity_err <= ((^r_shift) ^ r_par) != PARITY_ODD;
            r_frame_err  <= ~r_rx_s;
            if (r_rx_s) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_BREAK: begin
          if (r_rx_s) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data       = r_data;
  assign valid      = r_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign busy       = r_busy;

endmodule

// File: tb/tb_parity_uart_rx.sv
// tb/tb_parity_uart_rx.sv - scoreboard bench driving even- and odd-parity receivers from one line
module tb_parity_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data0, data1;
  logic       v0, v1, pe0, pe1, fe0, fe1, b0, b1;

  always #5 clk = ~clk;

  parity_uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) u_even (
    .clk(clk), .rst(rst), .rx(rx), .data(data0), .valid(v0),
    .parity_err(pe0), .frame_err(fe0), .busy(b0)
  );

  parity_uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b1)) u_odd (
    .clk(clk), .rst(rst), .rx(rx), .data(data1), .valid(v1),
    .parity_err(pe1), .frame_err(fe1), .busy(b1)
  );

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   vt[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic pv0 = 1'b0;
  logic pv1 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference: a frame's parity is good when the count of ones over data+parity
  // is even (even mode) or odd (odd mode); a low stop bit is a framing error.
  task automatic push(input logic [7:0] b, input logic p, input logic s);
    exp_t e;
    int   ones;
    ones = $countones(b) + int'(p);
    e.d = b; e.fe = ~s;
    e.pe = (ones % 2) != 0;
    q0.push_back(e);
    e.pe = (ones % 2) != 1;
    q1.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic p, input logic s);
    logic [10:0] bits;
    bits = {s, p, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx = bits[i];
      cycles(CPB);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst) begin
      if (v0) begin
        vt.push_back(cyc);
        chk("even_valid_double", {31'd0, pv0}, 32'd0);
        if (q0.size() == 0) chk("even_valid_unexpected", {31'd0, v0}, 32'd0);
        else begin
          e = q0.pop_front();
          chk("even_data", {24'd0, data0}, {24'd0, e.d});
          chk("even_parity_err", {31'd0, pe0}, {31'd0, e.pe});
          chk("even_frame_err", {31'd0, fe0}, {31'd0, e.fe});
        end
      end
      if (v1) begin
        chk("odd_valid_double", {31'd0, pv1}, 32'd0);
        if (q1.size() == 0) chk("odd_valid_unexpected", {31'd0, v1}, 32'd0);
        else begin
          e = q1.pop_front();
          chk("odd_data", {24'd0, data1}, {24'd0, e.d});
          chk("odd_parity_err", {31'd0, pe1}, {31'd0, e.pe});
          chk("odd_frame_err", {31'd0, fe1}, {31'd0, e.fe});
        end
      end
    end
    pv0 = v0;
    pv1 = v1;
  end

  task automatic chk_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_data"}, {16'd0, data0, data1}, 32'd0);
    chk({tag, "_valid"}, {30'd0, v0, v1}, 32'd0);
    chk({tag, "_flags"}, {28'd0, pe0, pe1, fe0, fe1}, 32'd0);
    chk({tag, "_busy"}, {30'd0, b0, b1}, 32'd0);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] held;
    logic [7:0] rb;
    logic       rp, rs;
    int         gap;

    rst = 1'b1;
    rx  = 1'b1;
    #1;
    cycles(3);
    chk_reset_outputs("reset");
    rst = 1'b0;
    cycles(4);

    push(8'hA5, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b0, 1'b1);
    rx = 1'b1;
    cycles(5);
    chk("a5_busy_after", {30'd0, b0, b1}, 32'd0);

    push(8'h07, 1'b0, 1'b1);
    send_frame(8'h07, 1'b0, 1'b1);
    rx = 1'b1;
    cycles(CPB);
    push(8'h07, 1'b1, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1);
    rx = 1'b1;
    cycles(CPB);

    // Stop bit low, then line held low: one errored frame, receiver parked until release.
    push(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0);
    cycles(40);
    chk("break_busy_held", {30'd0, b0, b1}, 32'd3);
    rx = 1'b1;
    cycles(4);
    chk("break_busy_release", {30'd0, b0, b1}, 32'd0);
    cycles(CPB);

    held = data0;
    rx = 1'b0;
    cycles(3);
    rx = 1'b1;
    cycles(CPB / 2 + 3);
    chk("glitch_busy", {30'd0, b0, b1}, 32'd0);
    chk("glitch_data", {24'd0, data0}, {24'd0, held});
    cycles(CPB);

    rx = 1'b0;
    cycles(CPB);
    rx = 1'b1;
    cycles(4 * CPB + CPB / 2);
    chk("midframe_busy", {30'd0, b0, b1}, 32'd3);
    rst = 1'b1;
    cycles(1);
    chk_reset_outputs("midframe_reset");
    cycles(2);
    chk_reset_outputs("midframe_reset_hold");
    rst = 1'b0;
    cycles(2 * CPB);
    push(8'h5A, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b1);
    rx = 1'b1;
    cycles(CPB);

    vt.delete();
    push(8'h01, 1'b1, 1'b1);
    send_frame(8'h01, 1'b1, 1'b1);
    push(8'h80, 1'b1, 1'b1);
    send_frame(8'h80, 1'b1, 1'b1);
    push(8'h55, 1'b0, 1'b1);
    send_frame(8'h55, 1'b0, 1'b1);
    rx = 1'b1;
    cycles(CPB);
    chk("b2b_count", vt.size(), 32'd3);
    for (int i = 1; i < vt.size(); i++)
      chk("b2b_spacing", vt[i] - vt[i-1], 11 * CPB);

    for (int n = 0; n < 24; n++) begin
      rb = 8'($urandom);
      rp = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 7) != 0);
      push(rb, rp, rs);
      send_frame(rb, rp, rs);
      rx = 1'b1;
      gap = rs ? int'($urandom_range(0, 20)) : CPB + int'($urandom_range(0, 20));
      if (gap > 0) cycles(gap);
    end

    cycles(2 * CPB);
    chk("even_queue_drained", q0.size(), 32'd0);
    chk("odd_queue_drained", q1.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
